// File: rtl/sram_load_seq.sv
// Byte-stream to SRAM write sequencer: packs bytes LSB-first into LOAD_SIZE-bit words.
// Optional checksum output enabled by defining SRAM_LOAD_CHECKSUM_EN.
module sram_load_seq #(
    parameter int LOAD_SIZE     = 16,
    parameter int MAX_LOCATIONS = 1024
) (
    input  logic                 pulse,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LOAD_SIZE-1:0] base_addr,
    input  logic [LOAD_SIZE-1:0] word_count,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic [LOAD_SIZE-1:0] addr_out,
    output logic [LOAD_SIZE-1:0] data_out,
    output logic                 wr_en,
    output logic                 busy,
    output logic                 done,
`ifdef SRAM_LOAD_CHECKSUM_EN
    output logic [7:0]           checksum,
`endif
    output logic                 err
);

    localparam int BYTES = LOAD_SIZE / 8;
    localparam int IDXW  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [LOAD_SIZE:0] LIMIT = (LOAD_SIZE + 1)'(MAX_LOCATIONS);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t               state_q;
    logic [IDXW-1:0]      idx_q;
    logic [LOAD_SIZE-1:0] word_q;
    logic [LOAD_SIZE-1:0] cur_addr_q;
    logic [LOAD_SIZE-1:0] remain_q;
    logic                 byte_ready_q;
    logic [LOAD_SIZE-1:0] addr_q;
    logic [LOAD_SIZE-1:0] data_q;
    logic                 wr_en_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
`ifdef SRAM_LOAD_CHECKSUM_EN
    logic [7:0]           csum_q;
`endif

    logic [LOAD_SIZE:0]   sum_d;
    logic                 range_err_d;
    logic [LOAD_SIZE-1:0] word_d;
    logic                 hs_d;
    logic                 last_byte_d;

    always_comb begin
        sum_d       = {1'b0, base_addr} + {1'b0, word_count};
        range_err_d = (sum_d > LIMIT);
        hs_d        = byte_valid && byte_ready_q;
        last_byte_d = (idx_q == IDXW'(BYTES - 1));
        word_d      = word_q;
        word_d[8*idx_q +: 8] = byte_in;
    end

    always_ff @(posedge pulse or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            word_q       <= '0;
            cur_addr_q   <= '0;
            remain_q     <= '0;
            byte_ready_q <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            wr_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef SRAM_LOAD_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cur_addr_q <= base_addr;
                        remain_q   <= word_count;
                        idx_q      <= '0;
                        word_q     <= '0;
                        busy_q     <= 1'b1;
`ifdef SRAM_LOAD_CHECKSUM_EN
                        csum_q     <= '0;
`endif
                        if (word_count == '0) begin
                            err_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (range_err_d) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            err_q        <= 1'b0;
                            byte_ready_q <= 1'b1;
                            state_q      <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (hs_d) begin
`ifdef SRAM_LOAD_CHECKSUM_EN
                        csum_q <= csum_q ^ byte_in;
`endif
                        if (last_byte_d) begin
                            // Write strobe is registered, so it lands the cycle after the last byte.
                            idx_q        <= '0;
                            data_q       <= word_d;
                            addr_q       <= cur_addr_q;
                            wr_en_q      <= 1'b1;
                            byte_ready_q <= 1'b0;
                            state_q      <= WRITE;
                        end else begin
                            word_q <= word_d;
                            idx_q  <= idx_q + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    wr_en_q    <= 1'b0;
                    cur_addr_q <= cur_addr_q + 1'b1;
                    remain_q   <= remain_q - 1'b1;
                    if (remain_q == LOAD_SIZE'(1)) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        byte_ready_q <= 1'b1;
                        state_q      <= RECV;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign byte_ready = byte_ready_q;
    assign addr_out   = addr_q;
    assign data_out   = data_q;
    assign wr_en      = wr_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
`ifdef SRAM_LOAD_CHECKSUM_EN
    assign checksum   = csum_q;
`endif

endmodule

// File: tb/tb_sram_load_seq.sv
// Scoreboard bench for sram_load_seq: expected writes/done events queued by stimulus,
// popped and compared by a monitor sampling on the falling edge.
module tb_sram_load_seq;

    logic        pulse = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [15:0] addr_out;
    logic [15:0] data_out;
    logic        wr_en;
    logic        busy;
    logic        done;
    logic        err;
`ifdef SRAM_LOAD_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    sram_load_seq #(.LOAD_SIZE(16), .MAX_LOCATIONS(1024)) dut (
        .pulse      (pulse),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .addr_out   (addr_out),
        .data_out   (data_out),
        .wr_en      (wr_en),
        .busy       (busy),
        .done       (done),
`ifdef SRAM_LOAD_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .err        (err)
    );

    always #5 pulse = ~pulse;

    typedef struct packed { logic [15:0] addr; logic [15:0] data; } wr_t;
    typedef struct packed { logic err; logic after_wr; logic [7:0] csum; } dn_t;

    wr_t  wq[$];
    dn_t  dq[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    logic [7:0] exp_csum = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic prev_wr = 1'b0;
        wr_t  w;
        dn_t  d;
        forever begin
            @(negedge pulse);
            if (!rst_n) begin
                prev_wr = 1'b0;
            end else begin
                if (wr_en) begin
                    check("ready_low_in_write", 32'(byte_ready), 32'd0);
                    if (wq.size() == 0) begin
                        check("unexpected_write", {addr_out, data_out}, 32'hxxxx_xxxx);
                    end else begin
                        w = wq.pop_front();
                        check("write_addr", 32'(addr_out), 32'(w.addr));
                        check("write_data", 32'(data_out), 32'(w.data));
                    end
                end
                if (done) begin
                    done_cnt++;
                    check("ready_low_in_done", 32'(byte_ready), 32'd0);
                    if (dq.size() == 0) begin
                        check("unexpected_done", 32'(done), 32'd0);
                    end else begin
                        d = dq.pop_front();
                        check("done_err", 32'(err), 32'(d.err));
                        check("done_after_write", 32'(prev_wr), 32'(d.after_wr));
`ifdef SRAM_LOAD_CHECKSUM_EN
                        check("done_checksum", 32'(checksum), 32'(d.csum));
`endif
                    end
                end
                prev_wr = wr_en;
            end
        end
    endtask

    task automatic do_start(input logic [15:0] b, input logic [15:0] c);
        @(posedge pulse); #1;
        start = 1'b1; base_addr = b; word_count = c;
        @(posedge pulse); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin @(posedge pulse); #1; end
        byte_valid = 1'b1; byte_in = b;
        n = 0;
        while (!byte_ready && n < 50) begin
            @(posedge pulse); #1;
            n++;
        end
        if (!byte_ready) check("byte_ready_timeout", 32'(byte_ready), 32'd1);
        @(posedge pulse); #1;
        byte_valid = 1'b0;
        exp_csum = exp_csum ^ b;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 200) begin
            @(posedge pulse); #1;
            n++;
        end
        if (done_cnt < target) check("done_timeout", 32'(done_cnt), 32'(target));
        @(posedge pulse); #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ready", 32'(byte_ready), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outputs"}, {byte_ready, wr_en, busy, done, err, addr_out | data_out}, 32'd0);
    endtask

    task automatic run_basic(input int maxgap);
        int t;
        logic [7:0] bytes [4];
        bytes[0] = 8'h34; bytes[1] = 8'h12; bytes[2] = 8'h78; bytes[3] = 8'h56;
        exp_csum = '0;
        t = done_cnt + 1;
        wq.push_back('{addr: 16'h0010, data: 16'h1234});
        wq.push_back('{addr: 16'h0011, data: 16'h5678});
        do_start(16'h0010, 16'd2);
        for (int i = 0; i < 4; i++) send_byte(bytes[i], $urandom_range(0, maxgap));
        dq.push_back('{err: 1'b0, after_wr: 1'b1, csum: exp_csum});
        wait_done(t);
    endtask

    initial begin
        int t;
        fork monitor(); join_none

        #12;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Test 1 and 2
        run_basic(0);
        run_basic(3);

        // Test 3a: out of range
        exp_csum = '0;
        t = done_cnt + 1;
        dq.push_back('{err: 1'b1, after_wr: 1'b0, csum: 8'h00});
        do_start(16'd1020, 16'd5);
        wait_done(t);
        check("err_sticky", 32'(err), 32'd1);

        // Test 3b: exactly fills to the last location
        exp_csum = '0;
        t = done_cnt + 1;
        for (int i = 0; i < 4; i++)
            wq.push_back('{addr: 16'(1020 + i), data: {8'(8'hB0 + i), 8'(8'hA0 + i)}});
        do_start(16'd1020, 16'd4);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'(8'hA0 + i), i % 2);
            send_byte(8'(8'hB0 + i), 0);
        end
        dq.push_back('{err: 1'b0, after_wr: 1'b1, csum: exp_csum});
        wait_done(t);

        // Test 4: zero count completes with done one cycle after start
        t = done_cnt + 1;
        dq.push_back('{err: 1'b0, after_wr: 1'b0, csum: 8'h00});
        do_start(16'h0100, 16'd0);
        check("zero_count_done_now", 32'({done, busy}), 32'b11);
        wait_done(t);

        // Test 5: reset mid-transfer, then a clean transfer
        do_start(16'h0020, 16'd2);
        send_byte(8'h11, 0);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(posedge pulse); #1;
        rst_n = 1'b1;
        exp_csum = '0;
        t = done_cnt + 1;
        wq.push_back('{addr: 16'h0000, data: 16'hABCD});
        do_start(16'h0000, 16'd1);
        send_byte(8'hCD, 0);
        send_byte(8'hAB, 1);
        dq.push_back('{err: 1'b0, after_wr: 1'b1, csum: exp_csum});
        wait_done(t);

        // Test 6: start during RECV is ignored
        exp_csum = '0;
        t = done_cnt + 1;
        wq.push_back('{addr: 16'h0100, data: 16'h1234});
        do_start(16'h0100, 16'd1);
        send_byte(8'h34, 0);
        do_start(16'h0200, 16'd3);
        check("start_ignored_busy", 32'(busy), 32'd1);
        send_byte(8'h12, 0);
        dq.push_back('{err: 1'b0, after_wr: 1'b1, csum: exp_csum});
        wait_done(t);

        repeat (3) @(posedge pulse);
        #1;
        check("writes_left", 32'(wq.size()), 32'd0);
        check("dones_left", 32'(dq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
